// File: rtl/verifier_compute_beta_par.sv
// beta(z, w) = prod_i [w_i*z_i + (1-w_i)*(1-z_i)] mod p, split across parallel element lanes,
// then combined (and optionally scaled) through one shared sequential field multiplier.
`default_nettype none

module verifier_field_mul #(
   parameter int                 F_NBITS = 61,
   parameter logic [F_NBITS-1:0] PRIME   = {F_NBITS{1'b1}}
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               en_i,
   input  logic [F_NBITS-1:0] a_i,
   input  logic [F_NBITS-1:0] b_i,
   output logic               done_o,
   output logic [F_NBITS-1:0] c_o
);
   localparam int CW = $clog2(F_NBITS + 1);
   localparam logic [F_NBITS:0] P_EXT = {1'b0, PRIME};

   logic [F_NBITS-1:0] a_q, b_q, acc_q, acc_d;
   logic [CW-1:0]      cnt_q;
   logic               busy_q, done_q;
   logic [F_NBITS:0]   dbl, dbl_r, sum;

   // MSB-first double-and-add, reducing after each doubling and each addition
   always_comb begin
      dbl   = {acc_q, 1'b0};
      dbl_r = (dbl >= P_EXT) ? dbl - P_EXT : dbl;
      sum   = dbl_r + (b_q[F_NBITS-1] ? {1'b0, a_q} : '0);
      acc_d = (sum >= P_EXT) ? F_NBITS'(sum - P_EXT) : sum[F_NBITS-1:0];
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         a_q    <= '0;
         b_q    <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (!busy_q && en_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            acc_q  <= '0;
            cnt_q  <= CW'(F_NBITS);
            busy_q <= 1'b1;
         end else if (busy_q) begin
            acc_q <= acc_d;
            b_q   <= {b_q[F_NBITS-2:0], 1'b0};
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done_o = done_q;
   assign c_o    = acc_q;
endmodule

module verifier_compute_beta_elem #(
   parameter int                 F_NBITS = 61,
   parameter logic [F_NBITS-1:0] PRIME   = {F_NBITS{1'b1}}
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               en_i,
   input  logic               restart_i,
   input  logic [F_NBITS-1:0] w_i,
   input  logic [F_NBITS-1:0] z_i,
   output logic               ready_o,
   output logic [F_NBITS-1:0] beta_o
);
   localparam logic [F_NBITS:0]   P_EXT = {1'b0, PRIME};
   localparam logic [F_NBITS-1:0] ONE   = F_NBITS'(1);

   typedef enum logic [1:0] {E_IDLE, E_WZ, E_ACC} estate_t;

   estate_t            state_q;
   logic [F_NBITS-1:0] w_q, z_q, src_q, beta_q;
   logic               mul_en, mul_done;
   logic [F_NBITS-1:0] mul_a, mul_b, mul_c, factor;

   function automatic logic [F_NBITS-1:0] addm(input logic [F_NBITS-1:0] a, input logic [F_NBITS-1:0] b);
      logic [F_NBITS:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= P_EXT) s = s - P_EXT;
      return s[F_NBITS-1:0];
   endfunction

   function automatic logic [F_NBITS-1:0] subm(input logic [F_NBITS-1:0] a, input logic [F_NBITS-1:0] b);
      return (a >= b) ? a - b : a + (PRIME - b);
   endfunction

   // w*z + (1-w)*(1-z) == 2wz - w - z + 1
   assign factor = subm(subm(addm(addm(mul_c, mul_c), ONE), w_q), z_q);

   assign mul_en = ((state_q == E_IDLE) && en_i) || ((state_q == E_WZ) && mul_done);
   assign mul_a  = (state_q == E_IDLE) ? w_i : src_q;
   assign mul_b  = (state_q == E_IDLE) ? z_i : factor;

   verifier_field_mul #(.F_NBITS(F_NBITS), .PRIME(PRIME)) u_mul (
      .clk    (clk),
      .rstb   (rstb),
      .en_i   (mul_en),
      .a_i    (mul_a),
      .b_i    (mul_b),
      .done_o (mul_done),
      .c_o    (mul_c)
   );

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= E_IDLE;
         w_q     <= '0;
         z_q     <= '0;
         src_q   <= '0;
         beta_q  <= '0;
      end else begin
         case (state_q)
            E_IDLE: if (en_i) begin
               w_q     <= w_i;
               z_q     <= z_i;
               src_q   <= restart_i ? ONE : beta_q;
               state_q <= E_WZ;
            end
            E_WZ:  if (mul_done) state_q <= E_ACC;
            E_ACC: if (mul_done) begin
               beta_q  <= mul_c;
               state_q <= E_IDLE;
            end
            default: state_q <= E_IDLE;
         endcase
      end
   end

   assign ready_o = (state_q == E_IDLE);
   assign beta_o  = beta_q;
endmodule

module verifier_compute_beta_par #(
   parameter int                 nCopyBits = 8,
   parameter int                 nLanes    = 2,
   parameter int                 F_NBITS   = 61,
   parameter logic [F_NBITS-1:0] PRIME     = {F_NBITS{1'b1}}
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               en,
   input  logic               scale_en,
   input  logic [F_NBITS-1:0] scale_in,
   input  logic [F_NBITS-1:0] w_vals [nCopyBits],
   input  logic [F_NBITS-1:0] z_vals [nCopyBits],
   output logic               ready,
   output logic [F_NBITS-1:0] beta_out
);
   localparam int SW  = $clog2(nCopyBits + 1);
   localparam int CXW = $clog2(nLanes + 1);

   if (nCopyBits < 2) begin : g_bad_ncopy
      $error("nCopyBits must be 2 or more");
   end
   if (nLanes < 1 || nLanes > nCopyBits) begin : g_bad_nlanes
      $error("nLanes must be within 1..nCopyBits");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_LANE_ST, S_LANE_RUN, S_COMB_ST, S_COMB_RUN, S_SCALE_ST, S_SCALE_RUN, S_FIN
   } state_t;

   state_t             state_q;
   logic               en_dly_q, scale_en_q, mul_en_q;
   logic [F_NBITS-1:0] scale_q, acc_q, mul_b_q, beta_out_q;
   logic [CXW-1:0]     cidx_q;
   logic               start, mul_done;
   logic [F_NBITS-1:0] mul_c, sel_part;
   logic [nLanes-1:0]  lane_done;
   logic [F_NBITS-1:0] lane_part [nLanes];

   assign start = en & ~en_dly_q;
   assign ready = (state_q == S_IDLE) & ~start;

   for (genvar k = 0; k < nLanes; k++) begin : g_lane
      localparam int STEPS = (nCopyBits - k + nLanes - 1) / nLanes;
      logic [SW-1:0]      cnt_q;
      logic               en_q, done_q, elem_rdy;
      logic [F_NBITS-1:0] w_sel, z_sel;

      // lane k walks bit indices k, k+nLanes, k+2*nLanes, ...
      always_comb begin
         w_sel = '0;
         z_sel = '0;
         for (int s = 0; s < STEPS; s++) begin
            if (cnt_q == SW'(s)) begin
               w_sel = w_vals[k + s*nLanes];
               z_sel = z_vals[k + s*nLanes];
            end
         end
      end

      verifier_compute_beta_elem #(.F_NBITS(F_NBITS), .PRIME(PRIME)) u_elem (
         .clk       (clk),
         .rstb      (rstb),
         .en_i      (en_q),
         .restart_i (cnt_q == '0),
         .w_i       (w_sel),
         .z_i       (z_sel),
         .ready_o   (elem_rdy),
         .beta_o    (lane_part[k])
      );

      always_ff @(posedge clk or negedge rstb) begin
         if (!rstb) begin
            cnt_q  <= '0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
         end else begin
            en_q <= 1'b0;
            if (state_q == S_IDLE && start) begin
               cnt_q  <= '0;
               done_q <= 1'b0;
            end else if (state_q == S_LANE_ST) begin
               en_q <= 1'b1;
            end else if (state_q == S_LANE_RUN && !en_q && !done_q && elem_rdy) begin
               cnt_q <= cnt_q + SW'(1);
               if (cnt_q == SW'(STEPS - 1)) done_q <= 1'b1;
               else                         en_q   <= 1'b1;
            end
         end
      end

      assign lane_done[k] = done_q;
   end

   always_comb begin
      sel_part = '0;
      for (int k = 0; k < nLanes; k++) begin
         if (cidx_q == CXW'(k)) sel_part = lane_part[k];
      end
   end

   verifier_field_mul #(.F_NBITS(F_NBITS), .PRIME(PRIME)) u_comb_mul (
      .clk    (clk),
      .rstb   (rstb),
      .en_i   (mul_en_q),
      .a_i    (acc_q),
      .b_i    (mul_b_q),
      .done_o (mul_done),
      .c_o    (mul_c)
   );

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q    <= S_IDLE;
         en_dly_q   <= 1'b1;
         scale_en_q <= 1'b0;
         scale_q    <= '0;
         acc_q      <= '0;
         cidx_q     <= '0;
         mul_en_q   <= 1'b0;
         mul_b_q    <= '0;
         beta_out_q <= '0;
      end else begin
         en_dly_q <= en;
         mul_en_q <= 1'b0;
         case (state_q)
            S_IDLE: if (start) begin
               scale_en_q <= scale_en;
               scale_q    <= scale_in;
               state_q    <= S_LANE_ST;
            end
            S_LANE_ST: state_q <= S_LANE_RUN;
            S_LANE_RUN: if (&lane_done) begin
               acc_q  <= lane_part[0];
               cidx_q <= CXW'(1);
               if (nLanes == 1) state_q <= scale_en_q ? S_SCALE_ST : S_FIN;
               else             state_q <= S_COMB_ST;
            end
            S_COMB_ST: begin
               mul_en_q <= 1'b1;
               mul_b_q  <= sel_part;
               state_q  <= S_COMB_RUN;
            end
            S_COMB_RUN: if (mul_done) begin
               acc_q  <= mul_c;
               cidx_q <= cidx_q + CXW'(1);
               if (cidx_q == CXW'(nLanes - 1)) state_q <= scale_en_q ? S_SCALE_ST : S_FIN;
               else                            state_q <= S_COMB_ST;
            end
            S_SCALE_ST: begin
               mul_en_q <= 1'b1;
               mul_b_q  <= scale_q;
               state_q  <= S_SCALE_RUN;
            end
            S_SCALE_RUN: if (mul_done) begin
               acc_q   <= mul_c;
               state_q <= S_FIN;
            end
            S_FIN: begin
               beta_out_q <= acc_q;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign beta_out = beta_out_q;
endmodule

`default_nettype wire

// File: tb/tb_verifier_compute_beta_par.sv
// Scoreboarded bench: four configurations (4/2, 3/1, 3/2, 3/3) run the same directed vectors.
`default_nettype none

module tb_verifier_compute_beta_par;
   localparam int F     = 61;
   localparam int LIMIT = 3000;

   logic         clk = 1'b0;
   logic         rstb, en, scale_en;
   logic [F-1:0] scale_in;
   logic [F-1:0] w4 [4];
   logic [F-1:0] z4 [4];
   logic [F-1:0] w3 [3];
   logic [F-1:0] z3 [3];
   logic         rdy [4];
   logic [F-1:0] bo  [4];
   bit           rdy_prev [4] = '{1'b1, 1'b1, 1'b1, 1'b1};

   int total = 0;
   int bad   = 0;
   logic [F-1:0] q0[$], q1[$], q2[$], q3[$];

   always #5 clk = ~clk;

   verifier_compute_beta_par #(.nCopyBits(4), .nLanes(2)) u_a (
      .clk(clk), .rstb(rstb), .en(en), .scale_en(scale_en), .scale_in(scale_in),
      .w_vals(w4), .z_vals(z4), .ready(rdy[0]), .beta_out(bo[0]));
   verifier_compute_beta_par #(.nCopyBits(3), .nLanes(1)) u_b (
      .clk(clk), .rstb(rstb), .en(en), .scale_en(scale_en), .scale_in(scale_in),
      .w_vals(w3), .z_vals(z3), .ready(rdy[1]), .beta_out(bo[1]));
   verifier_compute_beta_par #(.nCopyBits(3), .nLanes(2)) u_c (
      .clk(clk), .rstb(rstb), .en(en), .scale_en(scale_en), .scale_in(scale_in),
      .w_vals(w3), .z_vals(z3), .ready(rdy[2]), .beta_out(bo[2]));
   verifier_compute_beta_par #(.nCopyBits(3), .nLanes(3)) u_d (
      .clk(clk), .rstb(rstb), .en(en), .scale_en(scale_en), .scale_in(scale_in),
      .w_vals(w3), .z_vals(z3), .ready(rdy[3]), .beta_out(bo[3]));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic push4(input logic [F-1:0] a, input logic [F-1:0] b, input logic [F-1:0] c, input logic [F-1:0] d);
      q0.push_back(a); q1.push_back(b); q2.push_back(c); q3.push_back(d);
   endtask

   function automatic int qsize(input int j);
      case (j)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return q3.size();
      endcase
   endfunction

   function automatic logic [F-1:0] qpop(input int j);
      case (j)
         0: return q0.pop_front();
         1: return q1.pop_front();
         2: return q2.pop_front();
         default: return q3.pop_front();
      endcase
   endfunction

   // monitor: every rising ready outside reset is a result to check against the scoreboard
   always @(negedge clk) begin
      for (int j = 0; j < 4; j++) begin
         if (rstb && !rdy_prev[j] && rdy[j]) begin
            if (qsize(j) == 0) chk($sformatf("sb_underflow_dut%0d", j), qsize(j), 1);
            else               chk($sformatf("beta_out_dut%0d", j), bo[j], qpop(j));
         end
         rdy_prev[j] = rdy[j];
      end
   end

   task automatic set_vecs(input logic [F-1:0] w2_4, input logic w3ones);
      for (int i = 0; i < 4; i++) begin w4[i] = 1; z4[i] = 1; end
      w4[2] = w2_4;
      for (int i = 0; i < 3; i++) begin w3[i] = 1; z3[i] = 1; end
      if (!w3ones) begin w3[0] = 2; z3[0] = 3; end
   endtask

   task automatic run(input int toggle_at, input int scale_at, output int lat);
      int cyc;
      bit all_rdy;
      @(posedge clk); #1 en = 1'b1;
      #1 chk("ready_drop_on_start", rdy[0], 0);
      @(posedge clk); #1 en = 1'b0;
      cyc = 0; lat = -1; all_rdy = 0;
      while (!all_rdy && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
         if (cyc == toggle_at) en = 1'b1;
         else if (cyc == toggle_at + 1) en = 1'b0;
         if (cyc == scale_at) scale_in = 7;
         if (lat < 0 && rdy[0]) lat = cyc;
         all_rdy = rdy[0] & rdy[1] & rdy[2] & rdy[3];
      end
      chk("run_completes", all_rdy, 1);
   endtask

   initial begin
      int  lat0, lat1, lat2;
      bit  held_ok;
      rstb = 1'b0; en = 1'b1; scale_en = 1'b0; scale_in = '0;
      set_vecs(1, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("reset_beta_dut%0d", j), bo[j], 0);
         chk($sformatf("reset_ready_dut%0d", j), rdy[j], 1);
      end

      // en high across reset release must not start a run
      @(posedge clk); #2 rstb = 1'b1;
      held_ok = 1'b1;
      repeat (6) begin
         @(negedge clk);
         held_ok &= rdy[0] & rdy[1] & rdy[2] & rdy[3];
      end
      chk("en_held_no_start", held_ok, 1);
      @(posedge clk); #1 en = 1'b0;
      repeat (2) @(posedge clk);

      set_vecs(1, 1'b0);
      push4(1, 8, 8, 8);
      run(0, 0, lat0);

      // same vectors with a start request while busy
      push4(1, 8, 8, 8);
      run(20, 0, lat1);
      chk("busy_start_ignored_latency", lat1, lat0);

      set_vecs(0, 1'b0);
      scale_en = 1'b1; scale_in = 5;
      push4(0, 40, 40, 40);
      run(0, 30, lat2);
      chk("scale_adds_latency", lat2 > lat0, 1);
      scale_en = 1'b0; scale_in = '0;

      // abort mid-run with async reset; no result expected from this run
      set_vecs(1, 1'b1);
      @(posedge clk); #1 en = 1'b1;
      @(posedge clk); #1 en = 1'b0;
      repeat (15) @(posedge clk);
      #1 chk("busy_before_abort", rdy[0], 0);
      @(posedge clk); #1 rstb = 1'b0;
      #2;
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("abort_beta_dut%0d", j), bo[j], 0);
         chk($sformatf("abort_ready_dut%0d", j), rdy[j], 1);
      end
      @(posedge clk); #2 rstb = 1'b1;
      repeat (2) @(posedge clk);

      push4(1, 1, 1, 1);
      run(0, 0, lat0);
      repeat (3) @(posedge clk);

      for (int j = 0; j < 4; j++) chk($sformatf("sb_drained_dut%0d", j), qsize(j), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/verifier_compute_beta_par.md
Name: verifier_compute_beta_par

Overview:
Computes beta(z, w) = prod over i of [w_i*z_i + (1-w_i)*(1-z_i)] mod p across nCopyBits copy-variable pairs, split across nLanes parallel element lanes. A sequential combine stage then multiplies the lane partial products together and, optionally, by an external scale value. It sits in the verifier beside the per-layer sumcheck checker and serves wide copy counts, where a single serial beta chain is too slow.

Parameters:
nCopyBits, 8, number of (w_i, z_i) pairs; legal range is 2 or more (elaboration error otherwise).
nLanes, 2, number of parallel element lanes; legal range is 1 to nCopyBits (elaboration error otherwise).

Ports:
clk  in  1  clock
rstb  in  1  asynchronous, active-low reset
en  in  1  start request; rising-edge detected
scale_en  in  1  sampled at start; 1 means multiply the final product by scale_in
scale_in  in  F_NBITS  scale factor, sampled at start
w_vals  in  F_NBITS x nCopyBits  w coordinates; must be held stable while ready=0
z_vals  in  F_NBITS x nCopyBits  z coordinates; must be held stable while ready=0
ready  out  1  idle and result valid
beta_out  out  F_NBITS  result, held until the next start

Behaviour:
- Rising-edge detect: start = en & ~en_dly. en_dly resets to 1, so an en held high through reset does not start the block.
- ready = (state==IDLE) & ~start. ready drops combinationally in the start cycle.
- Reset values: state IDLE, ready 1, beta_out 0, all lane counters 0, scale latch 0.
- Lane assignment: lane k handles bit indices k, k+nLanes, k+2*nLanes, and so on while the index is below nCopyBits. Step count for lane k = ceil((nCopyBits-k)/nLanes).
- Each lane uses one verifier_compute_beta_elem instance with a local step counter. The first step runs with restart=1; later steps accumulate. Lane k holds done_k once its last step reports ready.
- All lanes start in the same cycle. Lanes finish independently, so shorter lanes idle holding their partial product.
- FSM states:
  - IDLE. On start: latch scale_en and scale_in, clear lane counters, go to LANE_ST.
  - LANE_ST. Pulse enable to every lane for one cycle, then go to LANE_RUN.
  - LANE_RUN. Each lane re-pulses its own enable for its next step in the cycle after its element reports ready, until that lane is done. When all done_k=1, go to COMB_ST with acc = lane0 partial and cidx = 1.
  - COMB_ST / COMB_RUN. One shared field multiplier computes acc*partial[cidx]. On mul ready: cidx++. When cidx == nLanes, go to SCALE_ST if scale_en, else go to FIN.
  - With nLanes=1, COMB is skipped entirely.
  - SCALE_ST / SCALE_RUN. Compute acc*scale_in, then go to FIN.
  - FIN. Register beta_out <= acc, go to IDLE. ready rises the cycle after FIN.
- All arithmetic is mod p using the codebase field_arith_defs. Inputs must be at or below p-1; behaviour for inputs at or above p is undefined.
- start while busy: ignored, with no restart and no state change.
- Async reset mid-operation: immediate return to reset values. The partial result is discarded and beta_out returns to 0.
- Counter widths: $clog2(nCopyBits+1) for lane step counters, $clog2(nLanes+1) for cidx.
- Latency: max over lanes of the sum of element latencies, plus (nLanes-1) multiplier latencies, plus scale_en times one multiplier latency, plus 2 cycles. The bench measures this latency and does not hard-code it.

Test Plan:
- nCopyBits=4, nLanes=2, all w_i=z_i=1, scale_en=0 -> beta_out=1, and ready returns to 1.
- Same configuration with w=(1,1,0,1), z=(1,1,1,1) -> beta_out=0 (factor for i=2 is 0).
- nCopyBits=3, nLanes=2, w=(2,1,1), z=(3,1,1) -> factor0 = 6+2 = 8, so beta_out=8. Repeat with nLanes=1 and nLanes=3 -> identical result.
- Previous vector with scale_en=1, scale_in=5 -> beta_out=40. Change scale_in mid-run to 7 -> still 40.
- en held high through reset release -> no start and ready stays 1. Toggle en high while busy -> ignored, single result.
- Assert rstb low mid-LANE_RUN, release, then start with all-ones vectors -> beta_out=0 during reset, then 1 after the clean run.
